// File: rtl/rf_wb_scheduler.sv
// Register-file write-port scheduler: fixed-priority source 0, round-robin over long-latency
// sources, registered RF write port and a 32-entry pending-write scoreboard driving decode stalls.
module rf_wb_scheduler #(
    parameter int N_REQ  = 3,
    parameter int DATA_W = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_REQ-1:0]        req_valid,
    input  logic [5*N_REQ-1:0]      req_rd,
    input  logic [DATA_W*N_REQ-1:0] req_data,
    output logic [N_REQ-1:0]        req_ready,
    input  logic                    issue_valid,
    input  logic [4:0]              issue_rd,
    input  logic [4:0]              rs1_addr,
    input  logic [4:0]              rs2_addr,
    output logic                    hazard,
    output logic [31:0]             busy,
    output logic                    rf_we,
    output logic [4:0]              rf_addr,
    output logic [DATA_W-1:0]       rf_data
);

    localparam int PTR_W = $clog2(N_REQ);

    logic [PTR_W-1:0]  rr_ptr;
    logic [PTR_W-1:0]  win;
    logic              found;
    int                idx;
    logic              xfer;
    logic [4:0]        win_rd;
    logic [DATA_W-1:0] win_data;
    logic [31:0]       busy_nxt;

    // NOTE: every variable gets a default at the top of always_comb so no path infers a latch.
    always_comb begin
        req_ready = '0;
        win       = '0;
        found     = 1'b0;
        idx       = 0;
        // Ready is forced low while reset is asserted, so no handshake can complete then.
        if (rst) begin
            if (req_valid[0]) begin
                req_ready[0] = 1'b1;
            end else begin
                for (int k = 0; k < N_REQ - 1; k++) begin
                    idx = ((int'(rr_ptr) - 1 + k) % (N_REQ - 1)) + 1;
                    if (!found && req_valid[idx]) begin
                        found          = 1'b1;
                        win            = PTR_W'(idx);
                        req_ready[idx] = 1'b1;
                    end
                end
            end
        end
    end

    assign xfer     = |(req_valid & req_ready);
    assign win_rd   = req_rd[5*int'(win) +: 5];
    assign win_data = req_data[DATA_W*int'(win) +: DATA_W];

    // A new issue is younger than the completing write, so the set is applied last and wins.
    always_comb begin
        busy_nxt = busy;
        if (xfer && win != '0) begin
            busy_nxt[win_rd] = 1'b0;
        end
        if (issue_valid && issue_rd != 5'd0) begin
            busy_nxt[issue_rd] = 1'b1;
        end
        busy_nxt[0] = 1'b0;
    end

    assign hazard = busy[rs1_addr] | busy[rs2_addr] | (issue_valid & busy[issue_rd]);

    // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rf_we   <= 1'b0;
            rf_addr <= '0;
            rf_data <= '0;
            busy    <= '0;
            rr_ptr  <= PTR_W'(1);
        end else begin
            rf_we <= xfer && (win_rd != 5'd0);
            if (xfer) begin
                rf_addr <= win_rd;
                rf_data <= win_data;
            end
            busy <= busy_nxt;
            if (xfer && win != '0) begin
                rr_ptr <= (int'(win) == N_REQ - 1) ? PTR_W'(1) : win + PTR_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_rf_wb_scheduler.sv
// Self-checking bench for rf_wb_scheduler: directed corner scenarios plus randomized traffic
// compared every cycle against a behavioural model of the write-port and scoreboard rules.
module tb_rf_wb_scheduler;

    localparam int N_REQ  = 3;
    localparam int DATA_W = 32;

    logic                    clk = 1'b0;
    logic                    rst;
    logic [N_REQ-1:0]        req_valid;
    logic [5*N_REQ-1:0]      req_rd;
    logic [DATA_W*N_REQ-1:0] req_data;
    logic [N_REQ-1:0]        req_ready;
    logic                    issue_valid;
    logic [4:0]              issue_rd;
    logic [4:0]              rs1_addr;
    logic [4:0]              rs2_addr;
    logic                    hazard;
    logic [31:0]             busy;
    logic                    rf_we;
    logic [4:0]              rf_addr;
    logic [DATA_W-1:0]       rf_data;

    int checks = 0;
    int errors = 0;

    rf_wb_scheduler #(.N_REQ(N_REQ), .DATA_W(DATA_W)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_rd(req_rd), .req_data(req_data), .req_ready(req_ready),
        .issue_valid(issue_valid), .issue_rd(issue_rd),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .hazard(hazard), .busy(busy),
        .rf_we(rf_we), .rf_addr(rf_addr), .rf_data(rf_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic              m_we;
    logic [4:0]        m_addr;
    logic [DATA_W-1:0] m_data;
    logic [31:0]       m_busy;
    int                m_rr;

    // Winner index, or -1 when nothing is granted.
    function automatic int m_grant(input logic r, input logic [N_REQ-1:0] v, input int rr);
        int cand;
        if (!r) return -1;
        if (v[0]) return 0;
        for (int k = 0; k < N_REQ - 1; k++) begin
            cand = rr + k;
            if (cand > N_REQ - 1) cand = cand - (N_REQ - 1);
            if (v[cand]) return cand;
        end
        return -1;
    endfunction

    int          mg;
    logic [4:0]  mrd;
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_we = 0; m_addr = 0; m_data = 0; m_busy = 0; m_rr = 1;
        end else begin
            mg = m_grant(rst, req_valid, m_rr);
            m_we = 0;
            if (mg >= 0) begin
                mrd    = req_rd[5*mg +: 5];
                m_we   = (mrd != 0);
                m_addr = mrd;
                m_data = req_data[DATA_W*mg +: DATA_W];
                if (mg >= 1) begin
                    m_busy[mrd] = 0;
                    m_rr = (mg == N_REQ - 1) ? 1 : mg + 1;
                end
            end
            if (issue_valid && issue_rd != 0) m_busy[issue_rd] = 1;
            m_busy[0] = 0;
        end
    end

    // Compare process: inputs change at posedge+2, so the falling edge sees settled values.
    int cg;
    always @(negedge clk) begin
        cg = m_grant(rst, req_valid, m_rr);
        check("req_ready", req_ready, (cg >= 0) ? (32'd1 << cg) : 32'd0);
        check("rf_we", rf_we, m_we);
        check("rf_addr", rf_addr, m_addr);
        check("rf_data", rf_data, m_data);
        check("busy", busy, m_busy);
        check("hazard", hazard,
              m_busy[rs1_addr] | m_busy[rs2_addr] | (issue_valid & m_busy[issue_rd]));
    end

    // ---------------- stimulus ----------------
    task automatic next_cycle();
        @(posedge clk);
        #2;
    endtask

    task automatic set_src(input int i, input logic [4:0] rd, input logic [DATA_W-1:0] d);
        req_rd[5*i +: 5]           = rd;
        req_data[DATA_W*i +: DATA_W] = d;
    endtask

    logic [N_REQ-1:0] rr_exp [4];

    initial begin
        rst = 1'b1;
        req_valid = '0; req_rd = '0; req_data = '0;
        issue_valid = 0; issue_rd = 0; rs1_addr = 0; rs2_addr = 0;
        #1 rst = 1'b0;

        // Reset with every source requesting.
        req_valid = 3'b111;
        set_src(0, 5'd5, 32'hA);
        set_src(1, 5'd6, 32'hB);
        set_src(2, 5'd8, 32'hC);
        @(negedge clk);
        check("rst_ready", req_ready, 0);
        check("rst_we", rf_we, 0);
        check("rst_busy", busy, 0);
        check("rst_addr", rf_addr, 0);

        // Release: source 0 has priority and is granted first.
        next_cycle();
        rst = 1'b1;
        @(negedge clk);
        check("prio_ready", req_ready, 3'b001);
        @(negedge clk);
        check("prio_we", rf_we, 1);
        check("prio_addr", rf_addr, 5);
        check("prio_data", rf_data, 32'hA);
        check("prio_stall", req_ready, 3'b001);

        // Round-robin between sources 1 and 2.
        next_cycle();
        req_valid = 3'b110;
        rr_exp[0] = 3'b010; rr_exp[1] = 3'b100; rr_exp[2] = 3'b010; rr_exp[3] = 3'b100;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("rr_grant", req_ready, rr_exp[i]);
        end

        // Scoreboard set, hazard, clear by long-latency writeback.
        next_cycle();
        req_valid = '0;
        issue_valid = 1; issue_rd = 7;
        next_cycle();
        issue_valid = 0; rs1_addr = 7;
        @(negedge clk);
        check("sb_busy7", busy, 32'h80);
        check("sb_hazard", hazard, 1);
        next_cycle();
        req_valid = 3'b100;
        set_src(2, 5'd7, 32'h77);
        @(negedge clk);
        check("sb_ready2", req_ready, 3'b100);
        check("sb_hazard_hold", hazard, 1);
        next_cycle();
        req_valid = '0;
        @(negedge clk);
        check("sb_clear", busy, 0);
        check("sb_hazard_drop", hazard, 0);
        check("sb_addr7", rf_addr, 7);

        // Same-edge set and clear of x9: set wins.
        next_cycle();
        rs1_addr = 0;
        issue_valid = 1; issue_rd = 9;
        req_valid = 3'b010;
        set_src(1, 5'd9, 32'h99);
        @(negedge clk);
        check("c_ready1", req_ready, 3'b010);
        next_cycle();
        issue_valid = 0; req_valid = '0;
        @(negedge clk);
        check("c_setwins", busy, 32'h200);
        check("c_addr9", rf_addr, 9);

        // x0 writeback: handshake completes, no RF write.
        next_cycle();
        req_valid = 3'b001;
        set_src(0, 5'd0, 32'h55);
        @(negedge clk);
        check("x0_ready", req_ready, 3'b001);
        next_cycle();
        req_valid = '0;
        issue_valid = 1; issue_rd = 0;
        @(negedge clk);
        check("x0_we", rf_we, 0);
        next_cycle();
        issue_valid = 0;
        @(negedge clk);
        check("x0_issue", busy, 32'h200);

        // Async reset mid-operation.
        next_cycle();
        req_valid = 3'b010;
        set_src(1, 5'd9, 32'h19);
        issue_valid = 1; issue_rd = 7;
        next_cycle();
        issue_valid = 0;
        req_valid = 3'b001;
        set_src(0, 5'd3, 32'h33);
        @(posedge clk);
        #3;
        check("ar_we_pre", rf_we, 1);
        check("ar_busy_pre", busy, 32'h80);
        rst = 1'b0;
        #1;
        check("ar_we", rf_we, 0);
        check("ar_busy", busy, 0);
        check("ar_ready", req_ready, 0);
        next_cycle();
        rst = 1'b1;
        req_valid = '0;

        // Randomized traffic.
        for (int n = 0; n < 2000; n++) begin
            next_cycle();
            rst         = ($urandom_range(0, 199) != 0);
            req_valid   = N_REQ'($urandom);
            if ($urandom_range(0, 2) != 0) req_valid[0] = 1'b0;
            for (int i = 0; i < N_REQ; i++) set_src(i, 5'($urandom), $urandom);
            issue_valid = ($urandom_range(0, 2) == 0);
            issue_rd    = 5'($urandom);
            rs1_addr    = 5'($urandom);
            rs2_addr    = 5'($urandom);
        end

        next_cycle();
        rst = 1'b1;
        req_valid = '0;
        issue_valid = 0;
        repeat (3) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
